// File: rtl/spi_reg_sequencer_if.sv
// Signal bundle between the host logic, spi_reg_sequencer and the quick_spi master.
// Requests transfer on a rising clk edge where req_valid and req_ready are both 1; rsp_valid is a one-cycle strobe with no ready.
interface spi_reg_sequencer_if #(
  parameter int ADDR_WIDTH       = 7,
  parameter int DATA_WIDTH       = 8,
  parameter int NUMBER_OF_SLAVES = 2,
  parameter int FIFO_DEPTH       = 4
);
  localparam int PEND_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [NUMBER_OF_SLAVES-1:0] req_slave;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic [DATA_WIDTH-1:0]       req_wdata;
  logic                        rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic                        rsp_timeout;
  logic [PEND_WIDTH-1:0]       pending;
  logic                        spi_enable;
  logic [NUMBER_OF_SLAVES-1:0] spi_slave;
  logic                        spi_operation;
  logic [15:0]                 spi_outgoing_data;
  logic                        spi_busy;
  logic [DATA_WIDTH-1:0]       spi_incoming_data;

  modport slave (
    input  req_valid, req_write, req_slave, req_addr, req_wdata,
    input  spi_busy, spi_incoming_data,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, pending,
    output spi_enable, spi_slave, spi_operation, spi_outgoing_data
  );

  modport master (
    output req_valid, req_write, req_slave, req_addr, req_wdata,
    output spi_busy, spi_incoming_data,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, pending,
    input  spi_enable, spi_slave, spi_operation, spi_outgoing_data
  );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Queues register read/write requests and runs one quick_spi transaction per request,
// returning read data or a timeout flag for each one in request order.
module spi_reg_sequencer #(
  parameter int ADDR_WIDTH       = 7,
  parameter int DATA_WIDTH       = 8,
  parameter int NUMBER_OF_SLAVES = 2,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_reg_sequencer_if.slave bus,
  output logic [2:0]         o_dbg_state
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + NUMBER_OF_SLAVES + ADDR_WIDTH + DATA_WIDTH;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESPOND   = 3'd4
  } state_t;

  logic [ENT_W-1:0]            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_req_ready;
  state_t                      r_state;
  logic [TMO_W-1:0]            r_tmo_cnt;
  logic                        r_inf_write;
  logic                        r_spi_enable;
  logic                        r_spi_operation;
  logic [NUMBER_OF_SLAVES-1:0] r_spi_slave;
  logic [15:0]                 r_spi_word;
  logic                        r_rsp_valid;
  logic                        r_rsp_timeout;
  logic [DATA_WIDTH-1:0]       r_rsp_data;

  logic                        w_push;
  logic                        w_pop;
  logic [CNT_W-1:0]            w_count_next;
  logic [ENT_W-1:0]            w_head;
  logic                        w_head_write;
  logic [NUMBER_OF_SLAVES-1:0] w_head_slave;
  logic [ADDR_WIDTH-1:0]       w_head_addr;
  logic [DATA_WIDTH-1:0]       w_head_wdata;
  logic                        w_tmo_hit;

  assign w_push       = bus.req_valid && r_req_ready;
  // Popping waits for an idle master, so an aborted transfer still in progress is never overlapped.
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0) && !bus.spi_busy;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head       = r_mem[r_rd_ptr];
  assign {w_head_write, w_head_slave, w_head_addr, w_head_wdata} = w_head;
  assign w_tmo_hit    = (r_tmo_cnt >= TMO_LAST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.req_write, bus.req_slave, bus.req_addr, bus.req_wdata};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_req_ready     <= 1'b1;
      r_state         <= S_IDLE;
      r_tmo_cnt       <= '0;
      r_inf_write     <= 1'b0;
      r_spi_enable    <= 1'b0;
      r_spi_operation <= 1'b0;
      r_spi_slave     <= '0;
      r_spi_word      <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_timeout   <= 1'b0;
      r_rsp_data      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_next;
      r_req_ready <= (w_count_next != FULL_CNT);

      r_spi_enable  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_data    <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_inf_write     <= w_head_write;
            r_spi_enable    <= 1'b1;
            r_spi_operation <= w_head_write;
            r_spi_slave     <= w_head_slave;
            // Bit 15 set marks a read; reads carry a zero data field.
            r_spi_word      <= 16'({~w_head_write, w_head_addr,
                                    (w_head_write ? w_head_wdata : {DATA_WIDTH{1'b0}})});
            r_state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (bus.spi_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (w_tmo_hit) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESPOND;
          end
        end
        S_WAIT_DONE: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (!bus.spi_busy) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_inf_write ? '0 : bus.spi_incoming_data;
            r_state     <= S_RESPOND;
          end else if (w_tmo_hit) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready         = r_req_ready;
  assign bus.pending           = r_count;
  assign bus.rsp_valid         = r_rsp_valid;
  assign bus.rsp_data          = r_rsp_data;
  assign bus.rsp_timeout       = r_rsp_timeout;
  assign bus.spi_enable        = r_spi_enable;
  assign bus.spi_slave         = r_spi_slave;
  assign bus.spi_operation     = r_spi_operation;
  assign bus.spi_outgoing_data = r_spi_word;
  assign o_dbg_state           = r_state;
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer with a behavioural quick_spi master holding a small register file.
module tb_spi_reg_sequencer;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int NS  = 2;
  localparam int FD  = 4;
  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] dbg_state;

  spi_reg_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUMBER_OF_SLAVES(NS), .FIFO_DEPTH(FD)) bus ();

  spi_reg_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUMBER_OF_SLAVES(NS),
    .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad = 0;
  logic [8:0]  exp_q[$];      // {timeout, data}
  logic [18:0] exp_cmd_q[$];  // {slave, operation, command word}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // behavioural quick_spi master
  logic        m_busy = 1'b0;
  logic [7:0]  m_rdata = 8'h00;
  int          m_cnt = 0;
  int          m_dur = 3;
  int          ign_req = 0;
  int          ign_ack = 0;
  bit          m_init = 1'b0;
  logic [1:0]  m_slave = 2'd0;
  logic        m_op = 1'b0;
  logic [15:0] m_word = 16'h0;
  logic [7:0]  regs [4][128];

  assign bus.spi_busy          = m_busy;
  assign bus.spi_incoming_data = m_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!m_init) begin
      for (int s = 0; s < 4; s++)
        for (int a = 0; a < 128; a++) regs[s][a] = 8'h00;
      regs[0][0] = 8'hE5;
      m_init = 1'b1;
    end
    if (!reset_n) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_rdata <= 8'h00;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        if (m_op) begin
          regs[m_slave][m_word[14:8]] = m_word[7:0];
          m_rdata <= 8'hC3;
        end else begin
          m_rdata <= regs[m_slave][m_word[14:8]];
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (bus.spi_enable) begin
      if (ign_ack < ign_req) begin
        ign_ack <= ign_ack + 1;
      end else begin
        m_busy  <= 1'b1;
        m_cnt   <= m_dur;
        m_slave <= bus.spi_slave;
        m_op    <= bus.spi_operation;
        m_word  <= bus.spi_outgoing_data;
      end
    end
  end

  // scoreboard monitor
  logic [18:0] mon_cmd;
  logic [8:0]  mon_rsp;
  logic [1:0]  launch_slave = 2'd0;
  int          launch_cyc = 0;
  int          lat;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.spi_enable) begin
        chk("enable_while_busy", 32'(bus.spi_busy), 32'd0);
        if (exp_cmd_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_launch: got word 0x%0h expected no launch", bus.spi_outgoing_data);
        end else begin
          mon_cmd = exp_cmd_q.pop_front();
          chk("cmd", 32'({bus.spi_slave, bus.spi_operation, bus.spi_outgoing_data}), 32'(mon_cmd));
          launch_slave = mon_cmd[18:17];
          launch_cyc   = cyc;
        end
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_rsp: got data 0x%0h timeout %0d expected no response",
                   bus.rsp_data, bus.rsp_timeout);
        end else begin
          mon_rsp = exp_q.pop_front();
          chk("rsp", 32'({bus.rsp_timeout, bus.rsp_data}), 32'(mon_rsp));
          chk("slave_hold", 32'(bus.spi_slave), 32'(launch_slave));
          if (mon_rsp[8]) begin
            lat = cyc - launch_cyc;
            chk("timeout_latency_in_range", 32'(lat >= TMO && lat <= TMO + 2), 32'd1);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send(input bit w, input logic [1:0] s, input logic [6:0] a, input logic [7:0] d,
                      input logic [15:0] exp_word, input logic [7:0] exp_data, input bit exp_tmo);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_slave = s;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (bus.req_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      bound_fail("req_ready_wait");
      bus.req_valid = 1'b0;
    end else begin
      exp_cmd_q.push_back({s, w, exp_word});
      exp_q.push_back({exp_tmo, exp_data});
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || dbg_state != 3'd0) && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) bound_fail(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (dbg_state != st && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) bound_fail(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_slave = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_spi_enable", 32'(bus.spi_enable), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_word", 32'(bus.spi_outgoing_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // single write, single read
    send(1'b1, 2'd1, 7'h2D, 8'h08, 16'h2D08, 8'h00, 1'b0);
    wait_drain("drain_write");
    send(1'b0, 2'd0, 7'h00, 8'h00, 16'h8000, 8'hE5, 1'b0);
    wait_drain("drain_read");

    // six back-to-back requests against a slow master
    m_dur = 30;
    send(1'b1, 2'd0, 7'h10, 8'hA1, 16'h10A1, 8'h00, 1'b0);
    send(1'b1, 2'd1, 7'h11, 8'hB2, 16'h11B2, 8'h00, 1'b0);
    send(1'b0, 2'd0, 7'h10, 8'h00, 16'h9000, 8'hA1, 1'b0);
    send(1'b0, 2'd1, 7'h11, 8'h00, 16'h9100, 8'hB2, 1'b0);
    send(1'b0, 2'd1, 7'h2D, 8'h00, 16'hAD00, 8'h08, 1'b0);
    @(negedge clk);
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    chk("full_pending", 32'(bus.pending), 32'd4);
    send(1'b1, 2'd0, 7'h7F, 8'hFF, 16'h7FFF, 8'h00, 1'b0);
    wait_drain("drain_burst");
    chk("drained_pending", 32'(bus.pending), 32'd0);

    // master ignores the first launch, next requests run normally
    m_dur = 3;
    ign_req = ign_req + 1;
    send(1'b0, 2'd0, 7'h10, 8'h00, 16'h9000, 8'h00, 1'b1);
    send(1'b1, 2'd1, 7'h20, 8'h5A, 16'h205A, 8'h00, 1'b0);
    send(1'b0, 2'd1, 7'h20, 8'h00, 16'hA000, 8'h5A, 1'b0);
    wait_drain("drain_timeout");

    // push and pop on the same edge with three entries queued
    m_dur = 30;
    send(1'b1, 2'd0, 7'h01, 8'h11, 16'h0111, 8'h00, 1'b0);
    send(1'b1, 2'd0, 7'h02, 8'h22, 16'h0222, 8'h00, 1'b0);
    send(1'b1, 2'd0, 7'h03, 8'h33, 16'h0333, 8'h00, 1'b0);
    send(1'b0, 2'd0, 7'h01, 8'h00, 16'h8100, 8'h11, 1'b0);
    wait_state(3'd4, "wait_respond");
    chk("pending_before_pushpop", 32'(bus.pending), 32'd3);
    send(1'b0, 2'd0, 7'h03, 8'h00, 16'h8300, 8'h33, 1'b0);
    @(negedge clk);
    chk("pending_after_pushpop", 32'(bus.pending), 32'd3);
    chk("state_after_pushpop", 32'(dbg_state), 32'd1);
    wait_drain("drain_pushpop");

    // reset while waiting for the master with two entries queued
    send(1'b1, 2'd1, 7'h05, 8'h55, 16'h0555, 8'h00, 1'b0);
    send(1'b0, 2'd1, 7'h05, 8'h00, 16'h8500, 8'h55, 1'b0);
    send(1'b0, 2'd0, 7'h7F, 8'h00, 16'hFF00, 8'hFF, 1'b0);
    wait_state(3'd3, "wait_done_state");
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("mid_rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("mid_rst_enable", 32'(bus.spi_enable), 32'd0);
    chk("mid_rst_operation", 32'(bus.spi_operation), 32'd0);
    chk("mid_rst_slave", 32'(bus.spi_slave), 32'd0);
    chk("mid_rst_word", 32'(bus.spi_outgoing_data), 32'd0);
    chk("mid_rst_pending", 32'(bus.pending), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    exp_cmd_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_mid_rst", 32'(bus.req_ready), 32'd1);
    chk("pending_after_mid_rst", 32'(bus.pending), 32'd0);
    repeat (5) @(negedge clk);
    send(1'b0, 2'd0, 7'h7F, 8'h00, 16'hFF00, 8'hFF, 1'b0);
    wait_drain("drain_after_reset");

    chk("leftover_rsp", 32'(exp_q.size()), 32'd0);
    chk("leftover_cmd", 32'(exp_cmd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
